fifo_arbiter: RTL

Multi-producer front end and read sequencer for the `fifo_buffer` instance in the wishbone_nn datapath. Up to NUM_REQ requesters (wishbone slave, NN layers) share the buffer's single write port through round-robin arbitration. One consumer drains the buffer through a registered valid/ready output. The block owns the buffer's `ce`/`we`/`rst` pins, keeps its own occupancy and pointer model, and never issues an illegal or hazardous operation.

---
 rtl/fifo_arbiter_if.sv | 36 +++
 rtl/fifo_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fifo_arbiter_if.sv
// Bundle of requester, consumer and buffer-side signals for fifo_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface fifo_arbiter_if #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter int NUM_REQ = 4
) ();
    localparam int LW = $clog2(DEPTH) + 1;

    logic                     flush;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;
    logic                     out_ready;
    logic [LW-1:0]            level;
    logic                     fifo_ce;
    logic                     fifo_we;
    logic                     fifo_rst;
    logic [WIDTH-1:0]         fifo_wdata;
    logic [WIDTH-1:0]         fifo_rdata;
    logic                     fifo_full;

    modport slave (
        input  flush, req_valid, req_data, out_ready, fifo_rdata, fifo_full,
        output req_ready, out_valid, out_data, level,
               fifo_ce, fifo_we, fifo_rst, fifo_wdata
    );

    modport master (
        output flush, req_valid, req_data, out_ready, fifo_rdata, fifo_full,
        input  req_ready, out_valid, out_data, level,
               fifo_ce, fifo_we, fifo_rst, fifo_wdata
    );
endinterface

// File: rtl/fifo_arbiter.sv
// Round-robin write arbiter and registered read sequencer in front of a
// single-port fifo_buffer. Issues at most one buffer op per cycle, tracks
// occupancy and pointers locally, and inserts a settle bubble after a wrap.
module fifo_arbiter #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter int NUM_REQ = 4
) (
    input  logic          clk,
    input  logic          rst,
    fifo_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int RW = $clog2(NUM_REQ);

    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);
    localparam logic [RW:0]   REQ_COUNT  = (RW + 1)'(NUM_REQ);
    localparam logic [RW-1:0] REQ_LAST   = RW'(NUM_REQ - 1);

    typedef enum logic [1:0] {S_INIT, S_RUN, S_FLUSH} state_t;
    typedef enum logic [1:0] {OP_IDLE, OP_WRITE, OP_READ} op_t;

    state_t             r_state;
    state_t             w_state_next;
    op_t                w_op;

    logic [LW-1:0]      r_level;
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [RW-1:0]      r_rr;
    logic               r_wr_first;
    logic               r_wr_bubble;
    logic               r_rd_bubble;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;

    logic               w_any_req;
    logic [RW-1:0]      w_grant;
    logic [RW-1:0]      w_rr_next;
    logic               w_wr_elig;
    logic               w_rd_elig;
    logic [NUM_REQ-1:0] w_req_ready;
    logic [WIDTH-1:0]   w_wdata;

    // Round-robin search: first valid requester starting at r_rr.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        logic [RW:0] idx;
        w_any_req = 1'b0;
        w_grant   = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, r_rr} + (RW + 1)'(k);
            if (idx >= REQ_COUNT) idx = idx - REQ_COUNT;
            if (!w_any_req && bus.req_valid[idx[RW-1:0]]) begin
                w_any_req = 1'b1;
                w_grant   = idx[RW-1:0];
            end
        end
    end

    assign w_rr_next = (w_grant == REQ_LAST) ? '0 : w_grant + 1'b1;

    assign w_wr_elig = w_any_req && (r_level != LEVEL_FULL) && !bus.fifo_full
                       && !r_wr_bubble;
    assign w_rd_elig = (r_level != '0) && (!r_out_valid || bus.out_ready)
                       && !r_rd_bubble;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_INIT;
        else     r_state <= w_state_next;
    end

    // Next state and op selection; ops only in S_RUN without a flush.
    always_comb begin
        w_state_next = r_state;
        w_op         = OP_IDLE;
        unique case (r_state)
            S_INIT:  w_state_next = S_RUN;
            S_RUN: begin
                if (bus.flush) begin
                    w_state_next = S_FLUSH;
                end else if (w_wr_elig && w_rd_elig) begin
                    w_op = r_wr_first ? OP_WRITE : OP_READ;
                end else if (w_wr_elig) begin
                    w_op = OP_WRITE;
                end else if (w_rd_elig) begin
                    w_op = OP_READ;
                end
            end
            S_FLUSH: w_state_next = S_RUN;
            default: w_state_next = S_INIT;
        endcase
    end

    // Grant decode and write-data mux; both are zero unless writing.
    always_comb begin
        w_req_ready = '0;
        w_wdata     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_op == OP_WRITE && w_grant == RW'(i)) begin
                w_req_ready[i] = 1'b1;
                w_wdata        = bus.req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Occupancy, pointers, arbitration state and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            r_level     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rr        <= '0;
            r_wr_first  <= 1'b0;
            r_wr_bubble <= 1'b0;
            r_rd_bubble <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (r_state == S_RUN && bus.flush) begin
            r_level     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rr        <= '0;
            r_wr_bubble <= 1'b0;
            r_rd_bubble <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_wr_bubble <= 1'b0;
            r_rd_bubble <= 1'b0;
            if (bus.out_ready) r_out_valid <= 1'b0;
            unique case (w_op)
                OP_WRITE: begin
                    r_level     <= r_level + 1'b1;
                    r_wr_ptr    <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
                    r_wr_bubble <= (r_wr_ptr == PTR_LAST);
                    r_rr        <= w_rr_next;
                    r_wr_first  <= 1'b0;
                end
                OP_READ: begin
                    r_level     <= r_level - 1'b1;
                    r_rd_ptr    <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
                    r_rd_bubble <= (r_rd_ptr == PTR_LAST);
                    r_out_data  <= bus.fifo_rdata;
                    r_out_valid <= 1'b1;
                    r_wr_first  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.fifo_wdata = w_wdata;
    assign bus.fifo_ce    = (w_op != OP_IDLE);
    assign bus.fifo_we    = (w_op == OP_WRITE);
    assign bus.fifo_rst   = (r_state != S_RUN);
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.level      = r_level;
endmodule
